des_round_ctrl: RTL and testbench
=================================

DES_ROUND_CTRL -- requirements
Module: des_round_ctrl

Interface
REQ-001 SHALL have parameter: NUM_ROUNDS, 16, rounds per block; legal range 1..16.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start_valid  input  1  requester has a block (IP-permuted data, PC1 key) ready.
REQ-005 SHALL have port: start_ready  output  1  controller accepts a new block.
REQ-006 SHALL have port: decrypt  input  1  mode, sampled only on start handshake (0 encrypt, 1 decrypt).
REQ-007 SHALL have port: flush  input  1  synchronous abort.
REQ-008 SHALL have port: load_en  output  1  datapath loads L/R and C/D registers.
REQ-009 SHALL have port: round_en  output  1  datapath updates L/R with expansion/S-box/P result.
REQ-010 SHALL have port: round_idx  output  4  current round, 0..NUM_ROUNDS-1.
REQ-011 SHALL have port: key_shift  output  2  C/D rotate amount this round (0, 1, 2).
REQ-012 SHALL have port: key_dir  output  1  rotate direction (0 left, 1 right), equals latched mode.
REQ-013 SHALL have port: final_swap  output  1  last round; datapath suppresses L/R swap.
REQ-014 SHALL have port: out_valid  output  1  result held in datapath is valid.
REQ-015 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-016 SHALL have port: busy  output  1  high in any state except IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, ROUND, DONE.
- IDLE: start_ready=1; start_valid&start_ready -> LOAD, latch decrypt.
- LOAD: one cycle, load_en=1, round_idx=0 -> ROUND.
- ROUND: round_en=1 each cycle; round_idx increments 0..NUM_ROUNDS-1; at NUM_ROUNDS-1 -> DONE.
- DONE: out_valid=1 held until out_ready; out_valid&out_ready -> IDLE.
REQ-018 SHALL give latency handshake-cycle T -> load_en at T+1, round_en T+2..T+1+NUM_ROUNDS, out_valid first at T+2+NUM_ROUNDS (T+18 for 16).
REQ-019 SHALL drive start_ready only in IDLE; a new block is never accepted in the cycle DONE completes (no back-to-back overlap).
REQ-020 SHALL drive key_shift from round_idx when round_en=1, else 0.
- Encrypt: 1 at idx 0, 1, 8, 15; 2 otherwise.
- Decrypt: 0 at idx 0; 1 at idx 1, 8, 15; 2 otherwise.
REQ-021 SHALL assert final_swap only when round_en=1 and round_idx=NUM_ROUNDS-1.
REQ-022 SHALL hold round_idx at 0 outside ROUND.
REQ-023 SHALL keep load_en, round_en, out_valid mutually exclusive.
REQ-024 SHALL, on flush=1, go to IDLE next cycle from any state, drop out_valid without handshake; flush overrides start_valid and out_ready in the same cycle.
REQ-025 SHALL ignore decrypt changes after the start handshake until the next handshake.
REQ-026 SHALL hold out_valid stable indefinitely while out_ready=0.

Reset
REQ-027 SHALL, on rst_n=0, immediately enter IDLE: start_ready=1, busy=0, load_en=0, round_en=0, out_valid=0, final_swap=0, round_idx=0, key_shift=0, key_dir=0.
REQ-028 SHALL, on reset mid-block, discard the block; no out_valid follows.

Structure
REQ-029 SHALL place FSM state enum, NUM_ROUNDS default and encrypt/decrypt shift tables in shared package des_pkg.
REQ-030 SHALL isolate the shift table in sub-module des_key_shift_sched (round_idx, decrypt -> key_shift).

Verification
REQ-031 Encrypt, out_ready=1: start at T -> load_en T+1, round_en T+2..T+17, key_shift 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, final_swap T+17, out_valid T+18, IDLE T+19.
REQ-032 Decrypt: key_dir=1, key_shift 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1; decrypt toggled mid-block has no effect.
REQ-033 Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid held, start_ready=0; out_ready=1 -> IDLE next cycle.
REQ-034 Flush at round_idx=7 with start_valid=1 -> IDLE next cycle, no out_valid, start accepted only the cycle after.
REQ-035 rst_n low asynchronously at round_idx=5 -> all outputs at reset values before the next clk edge.
REQ-036 NUM_ROUNDS=1: load_en T+1, single round_en with final_swap at T+2, out_valid T+3.

Source files
------------

// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared definitions for the DES round controller:
//   - des_state_e       : controller FSM state encoding
//   - DES_NUM_ROUNDS    : default number of rounds per block
//   - ENC/DEC_SHIFT_TBL : per-round C/D rotate amounts, 2 bits per round,
//                         round 0 in bits [1:0]
//   - shift_lookup()    : table lookup helper
// -----------------------------------------------------------------------------
package des_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } des_state_e;

  localparam int DES_NUM_ROUNDS = 16;

  // Encrypt rotates left by 1 in rounds 0,1,8,15 and by 2 elsewhere.
  // Bit pairs listed from round 15 (left) down to round 0 (right).
  localparam logic [31:0] ENC_SHIFT_TBL =
    32'b01_10_10_10_10_10_10_01_10_10_10_10_10_10_01_01;

  // Decrypt rotates right with the same schedule, except round 0 does not
  // rotate: PC1 output is already the round-16 key alignment.
  localparam logic [31:0] DEC_SHIFT_TBL =
    32'b01_10_10_10_10_10_10_01_10_10_10_10_10_10_01_00;

  function automatic logic [1:0] shift_lookup(input logic [3:0] idx,
                                              input logic       dec);
    logic [31:0] tbl;
    tbl = dec ? DEC_SHIFT_TBL : ENC_SHIFT_TBL;
    return tbl[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/des_key_shift_sched.sv
// -----------------------------------------------------------------------------
// des_key_shift_sched
// Maps the current round index and mode to the C/D rotate amount.
// Ports:
//   i_round_idx  in  4  current round index
//   i_decrypt    in  1  latched mode (0 encrypt, 1 decrypt)
//   i_round_en   in  1  a round is executing this cycle
//   o_key_shift  out 2  rotate amount (0..2); 0 when no round executes
// -----------------------------------------------------------------------------
module des_key_shift_sched
  import des_pkg::*;
(
  input  logic [3:0] i_round_idx,
  input  logic       i_decrypt,
  input  logic       i_round_en,
  output logic [1:0] o_key_shift
);

  logic [1:0] w_tbl_shift;

  assign w_tbl_shift = shift_lookup(i_round_idx, i_decrypt);
  assign o_key_shift = i_round_en ? w_tbl_shift : 2'd0;

endmodule

// File: rtl/des_round_ctrl.sv
// -----------------------------------------------------------------------------
// des_round_ctrl
// Sequences one DES block through load, NUM_ROUNDS rounds and result hold.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for a block; start_ready=1
//   ST_LOAD  | one cycle; datapath loads L/R and C/D (load_en=1)
//   ST_ROUND | one round per cycle; round_idx counts 0..NUM_ROUNDS-1
//   ST_DONE  | result valid (out_valid=1) until consumer takes it
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start_valid  in   requester offers a block
//   start_ready  out  controller accepts a block (IDLE only)
//   decrypt      in   mode, captured on the start handshake
//   flush        in   synchronous abort to IDLE
//   load_en      out  datapath load strobe
//   round_en     out  datapath round strobe
//   round_idx    out  current round (0 outside rounds)
//   key_shift    out  C/D rotate amount this cycle
//   key_dir      out  rotate direction (latched mode)
//   final_swap   out  last round; datapath suppresses L/R swap
//   out_valid    out  result valid
//   out_ready    in   consumer accepts result
//   busy         out  controller is not idle
//
// All strobes are registered: they are computed from the next state so they
// line up with the state register without a combinational decode stage.
// -----------------------------------------------------------------------------
module des_round_ctrl
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = DES_NUM_ROUNDS
)
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic       decrypt,
  input  logic       flush,
  output logic       load_en,
  output logic       round_en,
  output logic [3:0] round_idx,
  output logic [1:0] key_shift,
  output logic       key_dir,
  output logic       final_swap,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

  des_state_e r_state;
  des_state_e w_state_nxt;
  logic [3:0] r_round_idx;
  logic [3:0] w_idx_nxt;
  logic       w_latch_mode;
  logic       r_decrypt;
  logic       r_start_ready;
  logic       r_busy;
  logic       r_load_en;
  logic       r_round_en;
  logic       r_final_swap;
  logic       r_out_valid;
  logic [1:0] w_key_shift;

  // Next-state logic. flush wins over every other input, including a
  // start offer or a result handshake in the same cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = 4'd0;
    w_latch_mode = 1'b0;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_valid) begin
            w_state_nxt  = ST_LOAD;
            w_latch_mode = 1'b1;
          end
        end
        ST_LOAD: begin
          w_state_nxt = ST_ROUND;
        end
        ST_ROUND: begin
          if (r_round_idx == LAST_IDX) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_idx_nxt = r_round_idx + 4'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_round_idx   <= 4'd0;
      r_decrypt     <= 1'b0;
      r_start_ready <= 1'b1;
      r_busy        <= 1'b0;
      r_load_en     <= 1'b0;
      r_round_en    <= 1'b0;
      r_final_swap  <= 1'b0;
      r_out_valid   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_round_idx   <= w_idx_nxt;
      if (w_latch_mode) begin
        r_decrypt <= decrypt;
      end
      r_start_ready <= (w_state_nxt == ST_IDLE);
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_load_en     <= (w_state_nxt == ST_LOAD);
      r_round_en    <= (w_state_nxt == ST_ROUND);
      r_final_swap  <= (w_state_nxt == ST_ROUND) && (w_idx_nxt == LAST_IDX);
      r_out_valid   <= (w_state_nxt == ST_DONE);
    end
  end

  des_key_shift_sched u_shift_sched (
    .i_round_idx (r_round_idx),
    .i_decrypt   (r_decrypt),
    .i_round_en  (r_round_en),
    .o_key_shift (w_key_shift)
  );

  assign start_ready = r_start_ready;
  assign busy        = r_busy;
  assign load_en     = r_load_en;
  assign round_en    = r_round_en;
  assign round_idx   = r_round_idx;
  assign key_shift   = w_key_shift;
  assign key_dir     = r_decrypt;
  assign final_swap  = r_final_swap;
  assign out_valid   = r_out_valid;

endmodule

// File: tb/tb_des_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_des_round_ctrl
// Two controllers (16 rounds and 1 round) share one stimulus stream. A
// timeline model (cycles elapsed since the accepted start) predicts every
// output of both each cycle; directed sequences pin the model with literal
// expectations.
// -----------------------------------------------------------------------------
module tb_des_round_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_valid = 1'b0;
  logic decrypt = 1'b0;
  logic flush = 1'b0;
  logic out_ready = 1'b0;

  logic       sr[2], ld[2], re[2], kd[2], fs[2], ov[2], bz[2];
  logic [3:0] ri[2];
  logic [1:0] ks[2];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  des_round_ctrl #(.NUM_ROUNDS(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr[0]),
    .decrypt(decrypt), .flush(flush), .load_en(ld[0]), .round_en(re[0]),
    .round_idx(ri[0]), .key_shift(ks[0]), .key_dir(kd[0]), .final_swap(fs[0]),
    .out_valid(ov[0]), .out_ready(out_ready), .busy(bz[0])
  );

  des_round_ctrl #(.NUM_ROUNDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr[1]),
    .decrypt(decrypt), .flush(flush), .load_en(ld[1]), .round_en(re[1]),
    .round_idx(ri[1]), .key_shift(ks[1]), .key_dir(kd[1]), .final_swap(fs[1]),
    .out_valid(ov[1]), .out_ready(out_ready), .busy(bz[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Rotate amount straight from the DES key schedule.
  function automatic logic [1:0] spec_shift(input int idx, input bit dec);
    if (dec && idx == 0) return 2'd0;
    if (idx == 0 || idx == 1 || idx == 8 || idx == 15) return 2'd1;
    return 2'd2;
  endfunction

  // ---------------- timeline model ----------------
  int NR[2] = '{16, 1};
  bit m_act[2];
  int m_k[2];
  bit m_dec[2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_act[i] <= 1'b0;
        m_k[i]   <= 0;
        m_dec[i] <= 1'b0;
      end else if (flush) begin
        m_act[i] <= 1'b0;
      end else if (!m_act[i]) begin
        if (start_valid) begin
          m_act[i] <= 1'b1;
          m_k[i]   <= 1;
          m_dec[i] <= decrypt;
        end
      end else if (m_k[i] >= NR[i] + 2) begin
        if (out_ready) m_act[i] <= 1'b0;
      end else begin
        m_k[i] <= m_k[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        bit a;
        int k;
        bit e_re;
        int e_idx;
        a     = m_act[i];
        k     = m_k[i];
        e_re  = a && k >= 2 && k <= NR[i] + 1;
        e_idx = e_re ? k - 2 : 0;
        chk($sformatf("start_ready[%0d]", i), sr[i], !a);
        chk($sformatf("busy[%0d]", i), bz[i], a);
        chk($sformatf("load_en[%0d]", i), ld[i], a && k == 1);
        chk($sformatf("round_en[%0d]", i), re[i], e_re);
        chk($sformatf("round_idx[%0d]", i), ri[i], e_idx);
        chk($sformatf("final_swap[%0d]", i), fs[i], e_re && e_idx == NR[i] - 1);
        chk($sformatf("key_shift[%0d]", i), ks[i], e_re ? spec_shift(e_idx, m_dec[i]) : 2'd0);
        chk($sformatf("key_dir[%0d]", i), kd[i], m_dec[i]);
        chk($sformatf("out_valid[%0d]", i), ov[i], a && k >= NR[i] + 2);
      end
    end
  end

  // ---------------- directed traces ----------------
  logic       tr_ld[2][24], tr_re[2][24], tr_fs[2][24], tr_ov[2][24], tr_sr[2][24], tr_kd[2][24];
  logic [1:0] tr_ks[2][24];
  int ENC_EXP[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  int DEC_EXP[16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  task automatic run_trace(input bit dec, input int tog);
    start_valid = 1'b1;
    decrypt     = dec;
    out_ready   = 1'b1;
    for (int off = 0; off < 24; off++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        tr_ld[i][off] = ld[i];
        tr_re[i][off] = re[i];
        tr_fs[i][off] = fs[i];
        tr_ov[i][off] = ov[i];
        tr_sr[i][off] = sr[i];
        tr_kd[i][off] = kd[i];
        tr_ks[i][off] = ks[i];
      end
      @(posedge clk); #1;
      start_valid = 1'b0;
      if (off == tog) decrypt = ~decrypt;
    end
  endtask

  initial begin
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_state", {sr[0], bz[0], ld[0], re[0], ov[0], fs[0], ri[0], ks[0], kd[0]},
        13'b1_0_0_0_0_0_0000_00_0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Encrypt, consumer always ready.
    run_trace(1'b0, -1);
    begin
      int n_ld, n_re;
      n_ld = 0; n_re = 0;
      for (int o = 0; o < 24; o++) begin
        n_ld += int'(tr_ld[0][o]);
        n_re += int'(tr_re[0][o]);
      end
      chk("enc_load_at_T1", tr_ld[0][1], 1);
      chk("enc_load_count", n_ld, 1);
      chk("enc_round_count", n_re, 16);
      chk("enc_round_first_T2", tr_re[0][2], 1);
      chk("enc_round_last_T17", tr_re[0][17], 1);
      for (int r = 0; r < 16; r++)
        chk($sformatf("enc_ks_round%0d", r), tr_ks[0][r + 2], ENC_EXP[r]);
      chk("enc_final_swap_T16", tr_fs[0][16], 0);
      chk("enc_final_swap_T17", tr_fs[0][17], 1);
      chk("enc_out_valid_T17", tr_ov[0][17], 0);
      chk("enc_out_valid_T18", tr_ov[0][18], 1);
      chk("enc_start_ready_T18", tr_sr[0][18], 0);
      chk("enc_start_ready_T19", tr_sr[0][19], 1);
      chk("r1_load_T1", tr_ld[1][1], 1);
      chk("r1_round_T2", tr_re[1][2], 1);
      chk("r1_final_swap_T2", tr_fs[1][2], 1);
      chk("r1_key_shift_T2", tr_ks[1][2], 1);
      chk("r1_out_valid_T2", tr_ov[1][2], 0);
      chk("r1_out_valid_T3", tr_ov[1][3], 1);
      chk("r1_start_ready_T4", tr_sr[1][4], 1);
    end

    // Decrypt, mode input toggled mid-block.
    run_trace(1'b1, 6);
    for (int r = 0; r < 16; r++) begin
      chk($sformatf("dec_ks_round%0d", r), tr_ks[0][r + 2], DEC_EXP[r]);
      chk($sformatf("dec_key_dir_round%0d", r), tr_kd[0][r + 2], 1);
    end
    chk("dec_out_valid_T18", tr_ov[0][18], 1);
    chk("r1_dec_key_shift_T2", tr_ks[1][2], 0);
    chk("r1_dec_key_dir_T2", tr_kd[1][2], 1);

    // Backpressure in DONE.
    start_valid = 1'b1; decrypt = 1'b0; out_ready = 1'b0;
    for (int off = 0; off < 18; off++) begin
      @(negedge clk);
      @(posedge clk); #1;
      start_valid = 1'b0;
    end
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("bp_out_valid_held", ov[0], 1);
      chk("bp_start_ready_low", sr[0], 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_out_valid_at_accept", ov[0], 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_after_accept", {sr[0], ov[0], bz[0]}, 3'b100);
    @(posedge clk); #1;

    // Flush at round 7 with a competing start offer.
    start_valid = 1'b1; decrypt = 1'($urandom_range(0, 1)); out_ready = 1'b1;
    for (int off = 0; off < 9; off++) begin
      @(negedge clk);
      @(posedge clk); #1;
      start_valid = 1'b0;
    end
    flush = 1'b1; start_valid = 1'b1;
    @(negedge clk);
    chk("flush_at_round_idx", ri[0], 7);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_next", {bz[0], sr[0], ov[0], ld[0]}, 4'b0100);
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(negedge clk);
    chk("flush_start_taken_after", ld[0], 1);
    repeat (25) begin @(posedge clk); #1; end

    // Asynchronous reset at round 5.
    start_valid = 1'b1; decrypt = 1'b1; out_ready = 1'b1;
    for (int off = 0; off < 7; off++) begin
      @(negedge clk);
      @(posedge clk); #1;
      start_valid = 1'b0;
    end
    @(negedge clk);
    chk("rst_at_round_idx", ri[0], 5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_values", {sr[0], bz[0], ld[0], re[0], ov[0], fs[0], ri[0], ks[0], kd[0]},
        13'b1_0_0_0_0_0_0000_00_0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    begin
      int n_ov;
      n_ov = 0;
      repeat (25) begin
        @(negedge clk);
        n_ov += int'(ov[0]);
        @(posedge clk); #1;
      end
      chk("no_out_valid_after_reset", n_ov, 0);
    end

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      start_valid = 1'($urandom_range(0, 1));
      decrypt     = 1'($urandom_range(0, 1));
      out_ready   = ($urandom_range(0, 9) < 6);
      flush       = ($urandom_range(0, 99) < 3);
      rst_n       = ($urandom_range(0, 499) != 0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1; flush = 1'b0; start_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
